bbox_decode_sequencer: RTL and testbench
========================================

// Module: bbox_decode_sequencer
// PURPOSE
//  Frame-level controller for the bounding_box decode datapath (instantiated internally).
//  Walks every (cy, cx, anchor) slot of the detection grid.
//  Per slot: consumes one prediction word (tx,ty,tw,th) from the head stream, pairs it with
//  the grid coordinates and a programmable anchor size, and emits one decoded box on a
//  valid/ready stream to NMS.
// PARAMETERS
//  N            16  datapath word width, all box fields
//  GRID_W       13  grid columns
//  GRID_H       13  grid rows
//  NUM_ANCHORS  3   anchors per cell; anchor table depth
// PORTS
//  clk        in   1       system clock, rising edge
//  rst_n      in   1       asynchronous active-low reset
//  start      in   1       1-cycle pulse: begin frame (honoured only in IDLE)
//  busy       out  1       high from accepted start until done
//  done       out  1       1-cycle pulse after last slot handled
//  cfg_we     in   1       anchor table write strobe
//  cfg_idx    in   clog2(NUM_ANCHORS)  anchor index to write
//  cfg_aw     in   N       anchor width (Q6.10)
//  cfg_ah     in   N       anchor height (Q6.10)
//  pred_valid in   1       prediction word valid
//  pred_ready out  1       prediction word accepted when valid&ready
//  pred_data  in   4*N     {tx,ty,tw,th}, tx in MSBs
//  box_valid  out  1       decoded box valid
//  box_ready  in   1       downstream accepts
//  box_data   out  4*N     {bx,by,bw,bh}, bx in MSBs
//  box_last   out  1       qualifies final slot of frame
// BEHAVIOUR
//  Reset: busy=0, done=0, pred_ready=0, box_valid=0, box_data=0, box_last=0,
//    counters=0, anchor table all 0x0400 (1.0), state IDLE.
//  FSM: IDLE --start--> RUN --last slot accepted--> DRAIN --box handed off--> IDLE (done=1 one cycle).
//    start in RUN/DRAIN ignored.
//  Slot order: anchor fastest, then cx, then cy; counters wrap per dimension; final slot is
//    (GRID_H-1, GRID_W-1, NUM_ANCHORS-1).
//  pred_ready = (state==RUN) && (!box_valid || box_ready): single output register; full
//    throughput 1 slot/clk.
//  On pred handshake: box_data <= datapath(pred_data, cx, cy, anchor[a]) registered; box_valid<=1;
//    box_last<=final slot; counters advance.
//  Latency: 1 clk pred handshake -> box_valid.
//  box_valid held, box_data stable, until box_ready; box_valid clears on handshake with no new pred.
//  Arithmetic: bx=tx+cx, by=ty+cy (cx/cy zero-extended raw integers); bw=(tw*aw)>>10,
//    bh=(th*ah)>>10, 2N product truncated to low N bits after shift; all mod 2^N, no saturation.
//  cfg_we: accepted in any state; written entry used from the next slot fetch;
//    cfg_idx>=NUM_ANCHORS ignored.
//  cfg_we same cycle as a pred handshake on that index: old value used for that slot.
//  Reset mid-frame: all state abandoned immediately; partial box discarded; no done pulse.
// CONFIGURATION
//  BBOX_OBJ_FILTER_EN defined:
//    - pred_data widens to 5*N, {tobj,tx,ty,tw,th}; extra port cfg_thresh in N.
//    - slots with tobj < cfg_thresh (unsigned) consumed but not emitted.
//    - box_last only if final slot passes; frame end always marked by done.
//  Not defined: every slot emitted; pred_data 4*N; no cfg_thresh port.
// TESTING
//  Build GRID_W=2, GRID_H=2, NUM_ANCHORS=2, anchors {0x0400,0x0800} for w and h.
//  T1 reset: rst_n low mid-RUN -> all outputs 0 next edge; start after release runs clean frame.
//  T2 full frame, box_ready=1, pred tx=ty=5, tw=th=0x0400 ->
//    8 boxes, bx=5+cx, bw={0x0400,0x0800} alternating; box_last on 8th only; done 1 clk later.
//  T3 backpressure: box_ready low 3 clks on box 2 -> box_data stable, pred_ready=0,
//    no slot lost or duplicated.
//  T4 wrap: tx=0xFFFF at cx=1 -> bx=0x0000; tw=0xFFFF, aw=0x0800 -> bw=0xFFFE.
//  T5 start during RUN and cfg_we idx=1 aw=0x0C00 mid-frame ->
//    start ignored; later anchor-1 slots use 0x0C00; cfg_idx=2 ignored.
//  T6 (BBOX_OBJ_FILTER_EN) cfg_thresh=0x0100, tobj=0x00FF on final slot ->
//    7 boxes, no box_last, done asserted.

Source files
------------

// File: rtl/bbox_decode_sequencer_if.sv
// Stream bundle between the detection head, the decode sequencer and NMS.
// PW is the prediction word width (4*N, or 5*N when BBOX_OBJ_FILTER_EN adds tobj).
interface bbox_decode_sequencer_if #(
  parameter int N  = 16,
  parameter int PW = 4 * N
);
  logic          pred_valid;
  logic          pred_ready;
  logic [PW-1:0] pred_data;
  logic          box_valid;
  logic          box_ready;
  logic [4*N-1:0] box_data;
  logic          box_last;

  // master: head producer + NMS consumer side
  modport master (
    output pred_valid, pred_data, box_ready,
    input  pred_ready, box_valid, box_data, box_last
  );

  // slave: the decode sequencer
  modport slave (
    input  pred_valid, pred_data, box_ready,
    output pred_ready, box_valid, box_data, box_last
  );
endinterface

// File: rtl/bbox_decode_sequencer.sv
// Frame controller for bounding-box decode: walks (cy, cx, anchor) slots and emits one box per slot.
// Optional macro BBOX_OBJ_FILTER_EN: adds tobj to pred_data and drops slots with tobj < cfg_thresh.
//
// state   | meaning
// S_IDLE  | waiting for start; counters parked at zero
// S_RUN   | consuming prediction words, one slot per handshake
// S_DRAIN | final slot consumed; waiting for the last box to leave
module bbox_decode_sequencer #(
  parameter int N           = 16,
  parameter int GRID_W      = 13,
  parameter int GRID_H      = 13,
  parameter int NUM_ANCHORS = 3,
  localparam int IDXW       = (NUM_ANCHORS > 1) ? $clog2(NUM_ANCHORS) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic            busy,
  output logic            done,
  input  logic            cfg_we,
  input  logic [IDXW-1:0] cfg_idx,
  input  logic [N-1:0]    cfg_aw,
  input  logic [N-1:0]    cfg_ah,
`ifdef BBOX_OBJ_FILTER_EN
  input  logic [N-1:0]    cfg_thresh,
`endif
  bbox_decode_sequencer_if.slave bus
);

  localparam int CXW  = (GRID_W > 1) ? $clog2(GRID_W) : 1;
  localparam int CYW  = (GRID_H > 1) ? $clog2(GRID_H) : 1;
  localparam int FRAC = 10;

  localparam logic [CXW-1:0]  CX_MAX   = CXW'(GRID_W - 1);
  localparam logic [CYW-1:0]  CY_MAX   = CYW'(GRID_H - 1);
  localparam logic [IDXW-1:0] A_MAX    = IDXW'(NUM_ANCHORS - 1);
  localparam logic [IDXW:0]   NA_LIMIT = (IDXW + 1)'(NUM_ANCHORS);
  localparam logic [N-1:0]    ANCHOR_ONE = N'(1 << FRAC);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN
  } state_t;

  state_t          st_q, st_d;
  logic [CXW-1:0]  cx_q, cx_d;
  logic [CYW-1:0]  cy_q, cy_d;
  logic [IDXW-1:0] a_q, a_d;
  logic            box_valid_q, box_valid_d;
  logic            box_last_q, box_last_d;
  logic [4*N-1:0]  box_data_q, box_data_d;
  logic            done_q, done_d;
  logic [N-1:0]    aw_q [NUM_ANCHORS];
  logic [N-1:0]    aw_d [NUM_ANCHORS];
  logic [N-1:0]    ah_q [NUM_ANCHORS];
  logic [N-1:0]    ah_d [NUM_ANCHORS];

  logic            pred_ready_w;
  logic            pred_hs;
  logic            last_slot;
  logic            slot_pass;
  logic            cfg_wr;
  logic [4*N-1:0]  pred_box;
  logic [4*N-1:0]  box_calc;
  logic [N-1:0]    tx, ty, tw, th;
  logic [N-1:0]    cx_ext, cy_ext, aw_sel, ah_sel;
  logic [2*N-1:0]  prod_w, prod_h;
  logic            unused_prod;

`ifdef BBOX_OBJ_FILTER_EN
  assign pred_box  = bus.pred_data[4*N-1:0];
  assign slot_pass = (bus.pred_data[5*N-1:4*N] >= cfg_thresh);
`else
  assign pred_box  = bus.pred_data;
  assign slot_pass = 1'b1;
`endif

  assign pred_ready_w = (st_q == S_RUN) && (!box_valid_q || bus.box_ready);
  assign pred_hs      = bus.pred_valid && pred_ready_w;
  assign last_slot    = (a_q == A_MAX) && (cx_q == CX_MAX) && (cy_q == CY_MAX);
  assign cfg_wr       = cfg_we && ({1'b0, cfg_idx} < NA_LIMIT);

  assign cx_ext = N'(cx_q);
  assign cy_ext = N'(cy_q);
  assign aw_sel = aw_q[a_q];
  assign ah_sel = ah_q[a_q];

  // Decode datapath: offsets are raw grid integers, sizes are Q6.10 anchor scales.
  always_comb begin
    tx = pred_box[4*N-1:3*N];
    ty = pred_box[3*N-1:2*N];
    tw = pred_box[2*N-1:N];
    th = pred_box[N-1:0];
    prod_w = {{N{1'b0}}, tw} * {{N{1'b0}}, aw_sel};
    prod_h = {{N{1'b0}}, th} * {{N{1'b0}}, ah_sel};
    box_calc = {tx + cx_ext, ty + cy_ext, prod_w[N+FRAC-1:FRAC], prod_h[N+FRAC-1:FRAC]};
  end

  // Fraction bits and overflow above N are dropped by design (mod 2^N result).
  assign unused_prod = ^{prod_w[FRAC-1:0], prod_w[2*N-1:N+FRAC],
                         prod_h[FRAC-1:0], prod_h[2*N-1:N+FRAC]};

  always_comb begin
    aw_d = aw_q;
    ah_d = ah_q;
    if (cfg_wr) begin
      aw_d[cfg_idx] = cfg_aw;
      ah_d[cfg_idx] = cfg_ah;
    end
  end

  always_comb begin
    st_d        = st_q;
    cx_d        = cx_q;
    cy_d        = cy_q;
    a_d         = a_q;
    box_valid_d = box_valid_q;
    box_last_d  = box_last_q;
    box_data_d  = box_data_q;
    done_d      = 1'b0;

    case (st_q)
      S_IDLE: begin
        if (start) begin
          st_d = S_RUN;
          cx_d = '0;
          cy_d = '0;
          a_d  = '0;
        end
      end
      S_RUN: begin
        if (pred_hs && last_slot) begin
          st_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!box_valid_q || bus.box_ready) begin
          st_d   = S_IDLE;
          done_d = 1'b1;
        end
      end
      default: st_d = S_IDLE;
    endcase

    // A filtered slot still frees the output register if its box was being taken.
    if (pred_hs) begin
      box_valid_d = slot_pass;
      if (slot_pass) begin
        box_data_d = box_calc;
        box_last_d = last_slot;
      end
    end else if (bus.box_ready) begin
      box_valid_d = 1'b0;
    end

    if (pred_hs) begin
      if (a_q == A_MAX) begin
        a_d = '0;
        if (cx_q == CX_MAX) begin
          cx_d = '0;
          cy_d = (cy_q == CY_MAX) ? '0 : cy_q + 1'b1;
        end else begin
          cx_d = cx_q + 1'b1;
        end
      end else begin
        a_d = a_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q        <= S_IDLE;
      cx_q        <= '0;
      cy_q        <= '0;
      a_q         <= '0;
      box_valid_q <= 1'b0;
      box_last_q  <= 1'b0;
      box_data_q  <= '0;
      done_q      <= 1'b0;
      for (int i = 0; i < NUM_ANCHORS; i++) begin
        aw_q[i] <= ANCHOR_ONE;
        ah_q[i] <= ANCHOR_ONE;
      end
    end else begin
      st_q        <= st_d;
      cx_q        <= cx_d;
      cy_q        <= cy_d;
      a_q         <= a_d;
      box_valid_q <= box_valid_d;
      box_last_q  <= box_last_d;
      box_data_q  <= box_data_d;
      done_q      <= done_d;
      for (int i = 0; i < NUM_ANCHORS; i++) begin
        aw_q[i] <= aw_d[i];
        ah_q[i] <= ah_d[i];
      end
    end
  end

  assign busy           = (st_q != S_IDLE);
  assign done           = done_q;
  assign bus.pred_ready = pred_ready_w;
  assign bus.box_valid  = box_valid_q;
  assign bus.box_data   = box_data_q;
  assign bus.box_last   = box_last_q;

endmodule

// File: tb/tb_bbox_decode_sequencer.sv
// Bench for bbox_decode_sequencer on a 2x2 grid with 2 anchors; scoreboard of expected boxes
// filled at each prediction handshake and drained as boxes leave the DUT.
module tb_bbox_decode_sequencer;
  localparam int N  = 16;
  localparam int GW = 2;
  localparam int GH = 2;
  localparam int NA = 2;
`ifdef BBOX_OBJ_FILTER_EN
  localparam int PW = 5 * N;
`else
  localparam int PW = 4 * N;
`endif

  typedef struct {
    logic [63:0] data;
    logic        last;
  } sb_t;

  typedef struct {
    logic [63:0] pred;
    logic [63:0] box;
    logic        last;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        cfg_we = 1'b0;
  logic [0:0]  cfg_idx = 1'b0;
  logic [15:0] cfg_aw = 16'h0;
  logic [15:0] cfg_ah = 16'h0;
`ifdef BBOX_OBJ_FILTER_EN
  logic [15:0] cfg_thresh = 16'h0;
`endif
  logic        busy, done;

  bbox_decode_sequencer_if #(.N(N), .PW(PW)) bus_if ();

  bbox_decode_sequencer #(.N(N), .GRID_W(GW), .GRID_H(GH), .NUM_ANCHORS(NA)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_aw(cfg_aw), .cfg_ah(cfg_ah),
`ifdef BBOX_OBJ_FILTER_EN
    .cfg_thresh(cfg_thresh),
`endif
    .bus(bus_if)
  );

  always #5 clk = ~clk;

  int          n_pass = 0;
  int          n_total = 0;
  int          popped = 0;
  int          done_cnt = 0;
  bit          done_due = 1'b0;
  bit          free_done = 1'b0;
  int          k_model = 0;
  logic [15:0] am_w [NA];
  logic [15:0] am_h [NA];
  sb_t         sb [$];
  vec_t        vt [16];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", nm, act, exp);
  endtask

  function automatic logic [PW-1:0] ext(input logic [63:0] p, input logic [15:0] tobj);
    return PW'({tobj, p});
  endfunction

  function automatic sb_t model(input logic [63:0] p, input int k);
    sb_t r;
    int a, cx, cy;
    logic [31:0] pw, ph;
    a  = k % 2;
    cx = (k / 2) % 2;
    cy = k / 4;
    pw = 32'(p[31:16]) * 32'(am_w[a]);
    ph = 32'(p[15:0]) * 32'(am_h[a]);
    r.data = {16'(p[63:48] + 16'(cx)), 16'(p[47:32] + 16'(cy)), pw[25:10], ph[25:10]};
    r.last = (k == 7);
    return r;
  endfunction

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send_pred(input logic [PW-1:0] p, input sb_t e, input bit push);
    bus_if.pred_valid = 1'b1;
    bus_if.pred_data  = p;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus_if.pred_ready) begin
        if (push) sb.push_back(e);
        @(posedge clk); #1;
        bus_if.pred_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    chk("pred_accept_timeout", 64'd0, 64'd1);
    bus_if.pred_valid = 1'b0;
  endtask

  task automatic send_model(input logic [63:0] p);
    send_pred(ext(p, 16'hFFFF), model(p, k_model), 1'b1);
    k_model++;
  endtask

  task automatic start_frame();
    @(posedge clk); #1;
    chk("busy_before_start", 64'(busy), 64'd0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    k_model = 0;
    chk("busy_after_start", 64'(busy), 64'd1);
  endtask

  task automatic cfg_write(input logic [0:0] idx, input logic [15:0] aw, input logic [15:0] ah);
    @(posedge clk); #1;
    cfg_we = 1'b1; cfg_idx = idx; cfg_aw = aw; cfg_ah = ah;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    am_w[idx] = aw;
    am_h[idx] = ah;
  endtask

  task automatic wait_done();
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk); #1;
      if (done_cnt != d0) break;
    end
    chk("done_count", 64'(done_cnt - d0), 64'd1);
    chk("sb_empty", 64'(sb.size()), 64'd0);
  endtask

  task automatic reset_model();
    sb.delete();
    k_model  = 0;
    done_due = 1'b0;
    for (int i = 0; i < NA; i++) begin
      am_w[i] = 16'h0400;
      am_h[i] = 16'h0400;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},       64'(busy), 64'd0);
    chk({tag, "_done"},       64'(done), 64'd0);
    chk({tag, "_pred_ready"}, 64'(bus_if.pred_ready), 64'd0);
    chk({tag, "_box_valid"},  64'(bus_if.box_valid), 64'd0);
    chk({tag, "_box_data"},   bus_if.box_data, 64'd0);
    chk({tag, "_box_last"},   64'(bus_if.box_last), 64'd0);
  endtask

  // Output monitor: done timing and scoreboard drain, sampled mid-cycle.
  always @(negedge clk) begin
    sb_t e;
    if (rst_n) begin
      if (!free_done && (done || done_due)) begin
        chk("done_timing", 64'(done), 64'(done_due));
        if (done_due) chk("busy_at_done", 64'(busy), 64'd0);
      end
      done_due = 1'b0;
      if (done) done_cnt++;
      if (bus_if.box_valid && bus_if.box_ready) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected_box", bus_if.box_data, 64'd0);
        end else begin
          e = sb.pop_front();
          chk("box_data", bus_if.box_data, e.data);
          chk("box_last", 64'(bus_if.box_last), 64'(e.last));
          popped++;
          if (e.last) done_due = 1'b1;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [63:0] snap;
    logic [63:0] p;
    int          base;
    int          d0;
    sb_t         e;

    // Full frame, unity deltas: offsets follow the grid, sizes follow the anchors.
    vt[0]  = '{64'h0005_0005_0400_0400, 64'h0005_0005_0400_0400, 1'b0};
    vt[1]  = '{64'h0005_0005_0400_0400, 64'h0005_0005_0800_0800, 1'b0};
    vt[2]  = '{64'h0005_0005_0400_0400, 64'h0006_0005_0400_0400, 1'b0};
    vt[3]  = '{64'h0005_0005_0400_0400, 64'h0006_0005_0800_0800, 1'b0};
    vt[4]  = '{64'h0005_0005_0400_0400, 64'h0005_0006_0400_0400, 1'b0};
    vt[5]  = '{64'h0005_0005_0400_0400, 64'h0005_0006_0800_0800, 1'b0};
    vt[6]  = '{64'h0005_0005_0400_0400, 64'h0006_0006_0400_0400, 1'b0};
    vt[7]  = '{64'h0005_0005_0400_0400, 64'h0006_0006_0800_0800, 1'b1};
    // Wrap-around and truncation cases.
    vt[8]  = '{64'h0001_0002_0003_0004, 64'h0001_0002_0003_0004, 1'b0};
    vt[9]  = '{64'hFFFF_0000_FFFF_0001, 64'hFFFF_0000_FFFE_0002, 1'b0};
    vt[10] = '{64'hFFFF_1234_8000_0400, 64'h0000_1234_8000_0400, 1'b0};
    vt[11] = '{64'hFFFF_FFFF_0123_FFFF, 64'h0000_FFFF_0246_FFFE, 1'b0};
    vt[12] = '{64'h0010_FFFF_0001_07FF, 64'h0010_0000_0001_07FF, 1'b0};
    vt[13] = '{64'h0000_0000_0001_0000, 64'h0000_0001_0002_0000, 1'b0};
    vt[14] = '{64'h7FFF_7FFF_0000_0000, 64'h8000_8000_0000_0000, 1'b0};
    vt[15] = '{64'hFFFE_FFFE_8001_8001, 64'hFFFF_FFFF_0002_0002, 1'b1};

    bus_if.pred_valid = 1'b0;
    bus_if.pred_data  = '0;
    bus_if.box_ready  = 1'b1;
    reset_model();

    repeat (2) @(negedge clk);
    chk_all_zero("rst");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // T1: reset in the middle of a frame
    start_frame();
    for (int k = 0; k < 3; k++) send_model({16'(k), 16'(k + 1), 16'h0400, 16'h0400});
    rst_n = 1'b0;
    @(negedge clk);
    chk_all_zero("t1");
    reset_model();
    d0 = done_cnt;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("t1_no_done", 64'(done_cnt), 64'(d0));

    // T2: full frame with anchors {1.0, 2.0}
    cfg_write(1'b1, 16'h0800, 16'h0800);
    start_frame();
    for (int i = 0; i < 8; i++) begin
      e.data = vt[i].box;
      e.last = vt[i].last;
      send_pred(ext(vt[i].pred, 16'hFFFF), e, 1'b1);
    end
    wait_done();

    // T4: arithmetic wrap and truncation
    start_frame();
    for (int i = 8; i < 16; i++) begin
      e.data = vt[i].box;
      e.last = vt[i].last;
      send_pred(ext(vt[i].pred, 16'hFFFF), e, 1'b1);
    end
    wait_done();

    // T3: backpressure on the second box
    start_frame();
    base = popped;
    fork
      begin
        for (int k = 0; k < 8; k++)
          send_model({16'(k * 3), 16'(16'h0100 + k), 16'(16'h0400 + k * 16'h40), 16'(16'h0800 - k)});
      end
      begin
        for (int i = 0; i < 60; i++) begin
          @(negedge clk); #1;
          if (popped >= base + 1) break;
        end
        @(posedge clk); #1;
        bus_if.box_ready = 1'b0;
        @(negedge clk);
        snap = bus_if.box_data;
        chk("t3_box_valid_held", 64'(bus_if.box_valid), 64'd1);
        chk("t3_pred_ready_low", 64'(bus_if.pred_ready), 64'd0);
        for (int i = 0; i < 2; i++) begin
          @(negedge clk);
          chk("t3_box_data_stable", bus_if.box_data, snap);
          chk("t3_pred_ready_low", 64'(bus_if.pred_ready), 64'd0);
        end
        @(posedge clk); #1;
        bus_if.box_ready = 1'b1;
      end
    join
    wait_done();
    chk("t3_box_count", 64'(popped - base), 64'd8);

    // T5: ignored start mid-frame, anchor rewrite racing a handshake
    start_frame();
    for (int k = 0; k < 8; k++) begin
      if (k == 3) begin
        cfg_we = 1'b1; cfg_idx = 1'b1; cfg_aw = 16'h0C00; cfg_ah = 16'h0800;
      end
      if (k == 5) start = 1'b1;
      send_model({16'(k), 16'(2 * k), 16'h0400, 16'h0400});
      if (k == 3) begin
        cfg_we = 1'b0;
        am_w[1] = 16'h0C00;
        am_h[1] = 16'h0800;
      end
      if (k == 5) begin
        start = 1'b0;
        chk("t5_busy_after_start", 64'(busy), 64'd1);
      end
    end
    wait_done();

`ifdef BBOX_OBJ_FILTER_EN
    // T6: final slot below the objectness threshold
    cfg_thresh = 16'h0100;
    free_done  = 1'b1;
    base = popped;
    start_frame();
    for (int k = 0; k < 8; k++) begin
      p = {16'(k), 16'(k), 16'h0400, 16'h0400};
      e = model(p, k);
      e.last = 1'b0;
      send_pred(ext(p, (k == 7) ? 16'h00FF : 16'h0200), e, k != 7);
      k_model++;
    end
    wait_done();
    chk("t6_box_count", 64'(popped - base), 64'd7);
    free_done = 1'b0;
`endif

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
